// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: write-back has priority, multi-cycle
// results queue in a FIFO and drain into idle slots or a forced stall.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wreg,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_wdata,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  hz_rs1,
  input  logic [4:0]  hz_rs2,
  output logic        hz_hit1,
  output logic        hz_hit2
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_rd_q  [DEPTH];
  logic [31:0]   r_dat_q [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_starve;
  logic          r_from_mc;

  logic w_empty;
  logic w_busy;
  logic w_push;
  logic w_pop;

  assign w_empty    = (r_count == '0);
  assign mc_ready   = ~rst & (r_count < (AW+1)'(DEPTH));
  assign pipe_stall = ~rst & ~w_empty &
                      (r_starve == SW'(STARVE_LIMIT));
  assign w_busy     = pipe_wreg & (pipe_rd != 5'd0) & ~pipe_stall;
  assign w_push     = mc_valid & mc_ready & (mc_rd != 5'd0);
  assign w_pop      = ~rst & ~w_empty & ~w_busy;

  // A register is pending while queued or while its popped write is in flight
  function automatic logic f_pend(input logic [4:0] rs);
    logic          hit;
    logic [AW-1:0] idx;
    hit = r_from_mc & rf_we & (rf_rd == rs);
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rptr + AW'(i);
      if (((AW+1)'(i) < r_count) && (r_rd_q[idx] == rs))
        hit = 1'b1;
    end
    return hit & (rs != 5'd0);
  endfunction

  assign hz_hit1 = ~rst & f_pend(hz_rs1);
  assign hz_hit2 = ~rst & f_pend(hz_rs2);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_q[r_wptr]  <= mc_rd;
      r_dat_q[r_wptr] <= mc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_from_mc <= 1'b0;
      rf_we     <= 1'b0;
      rf_rd     <= 5'd0;
      rf_wdata  <= 32'd0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

      if (w_pop || w_empty)
        r_starve <= '0;
      else if (r_starve != SW'(STARVE_LIMIT))
        r_starve <= r_starve + SW'(1);

      if (w_busy) begin
        rf_we     <= 1'b1;
        rf_rd     <= pipe_rd;
        rf_wdata  <= pipe_wdata;
        r_from_mc <= 1'b0;
      end else if (w_pop) begin
        rf_we     <= 1'b1;
        rf_rd     <= r_rd_q[r_rptr];
        rf_wdata  <= r_dat_q[r_rptr];
        r_from_mc <= 1'b1;
      end else begin
        rf_we     <= 1'b0;
        r_from_mc <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed stimulus queues expected
// register-file writes, a negedge monitor pops and compares them.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wreg;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_wdata;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  hz_rs1;
  logic [4:0]  hz_rs2;
  logic        hz_hit1;
  logic        hz_hit2;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_wreg(pipe_wreg), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_rd(mc_rd), .mc_wdata(mc_wdata),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
    .hz_hit1(hz_hit1), .hz_hit2(hz_hit2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [36:0] act,
                     input logic [36:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected actual=%0d/%0h required=none",
                 rf_rd, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_data", {rf_rd, rf_wdata}, mon_e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wreg  = 1'b0;
    pipe_rd    = 5'd0;
    pipe_wdata = 32'd0;
    mc_valid   = 1'b0;
    mc_rd      = 5'd0;
    mc_wdata   = 32'd0;
  endtask

  task automatic pw(input logic [4:0] rd, input logic [31:0] d);
    pipe_wreg  = 1'b1;
    pipe_rd    = rd;
    pipe_wdata = d;
    exp_q.push_back({rd, d});
  endtask

  task automatic mc(input logic [4:0] rd, input logic [31:0] d);
    mc_valid = 1'b1;
    mc_rd    = rd;
    mc_wdata = d;
  endtask

  initial begin
    idle();
    hz_rs1 = 5'd5;
    hz_rs2 = 5'd7;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ready", mc_ready, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_hit1", hz_hit1, 0);
    chk("rst_hit2", hz_hit2, 0);

    // pipe write appears one cycle later
    cyc();
    rst = 1'b0;
    pw(5'd5, 32'hDEADBEEF);
    cyc();
    idle();
    @(negedge clk);

    // single mc push, two-cycle latency, hazard while pending
    cyc();
    mc(5'd7, 32'h12);
    exp_q.push_back({5'd7, 32'h12});
    @(negedge clk);
    chk("t2_ready", mc_ready, 1);
    cyc();
    idle();
    hz_rs1 = 5'd7;
    hz_rs2 = 5'd3;
    @(negedge clk);
    chk("t2_hit1_q", hz_hit1, 1);
    chk("t2_hit2_q", hz_hit2, 0);
    chk("t2_we_lat", rf_we, 0);
    cyc();
    @(negedge clk);
    chk("t2_hit1_out", hz_hit1, 1);
    cyc();
    @(negedge clk);
    chk("t2_hit1_clr", hz_hit1, 0);

    // fill FIFO under a busy pipe, then drain in order
    for (int k = 0; k < 4; k++) begin
      cyc();
      pw(5'(10 + k), 32'hA0 + 32'(k));
      mc(5'(20 + k), 32'hB00 + 32'(k));
      @(negedge clk);
      chk("t3_ready", mc_ready, 1);
    end
    cyc();
    pw(5'd14, 32'hA4);
    mc(5'd24, 32'hBAD);
    @(negedge clk);
    chk("t3_full", mc_ready, 0);
    chk("t3_nostall", pipe_stall, 0);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({5'(20 + k), 32'hB00 + 32'(k)});
    cyc();
    idle();
    @(negedge clk);
    chk("t3_full2", mc_ready, 0);
    cyc();
    @(negedge clk);
    chk("t3_ready2", mc_ready, 1);
    repeat (4) cyc();

    // starvation: forced stall exactly on cycle 9
    for (int k = 0; k <= 10; k++) begin
      cyc();
      pipe_wreg  = 1'b1;
      pipe_rd    = 5'(k + 1);
      pipe_wdata = 32'h100 + 32'(k);
      if (k == 0) mc(5'd9, 32'h99);
      else mc_valid = 1'b0;
      if (k == 9) exp_q.push_back({5'd9, 32'h99});
      else exp_q.push_back({5'(k + 1), 32'h100 + 32'(k)});
      @(negedge clk);
      chk("t4_stall", pipe_stall, (k == 9) ? 1 : 0);
    end
    cyc();
    idle();
    cyc();

    // rd=0 writes are dropped; dropped push takes no slot
    cyc();
    pipe_wreg  = 1'b1;
    pipe_wdata = 32'h55;
    mc(5'd0, 32'h66);
    @(negedge clk);
    chk("t5_ready", mc_ready, 1);
    cyc();
    idle();
    @(negedge clk);
    chk("t5_we0", rf_we, 0);
    cyc();
    @(negedge clk);
    chk("t5_we1", rf_we, 0);

    // reset flushes three queued entries
    for (int k = 0; k < 3; k++) begin
      cyc();
      pw(5'd1, 32'h300 + 32'(k));
      mc(5'(3 + k), 32'h400 + 32'(k));
    end
    cyc();
    pw(5'd1, 32'h3FF);
    mc_valid = 1'b0;
    hz_rs1 = 5'd3;
    hz_rs2 = 5'd5;
    @(negedge clk);
    chk("t6_ready3", mc_ready, 1);
    chk("t6_hit1", hz_hit1, 1);
    chk("t6_hit2", hz_hit2, 1);
    cyc();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", mc_ready, 0);
    chk("t6_rst_hit1", hz_hit1, 0);
    chk("t6_rst_stall", pipe_stall, 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_we", rf_we, 0);
    chk("t6_ready", mc_ready, 1);
    chk("t6_hit1_clr", hz_hit1, 0);
    chk("t6_hit2_clr", hz_hit2, 0);
    repeat (4) cyc();
    chk("sb_drained", 37'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
